// File: rtl/series_cu_pkg.sv
// Shared types for the power-series controller: state encoding and a latency helper.
package series_cu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    ADD  = 3'd2,
    MUL  = 3'd3,
    LD   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Edges from the start-sampling edge to the edge that enters DONE.
  function automatic int series_latency(input int n_terms, input int mul_lat);
    return 1 + n_terms + (n_terms - 1) * (mul_lat + 1);
  endfunction

endpackage

// File: rtl/series_cnt.sv
// Up-counter with synchronous clear (priority over enable) and terminal-count flag.
module series_cnt #(
  parameter int W   = 4,
  parameter int MAX = 7
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(MAX));

endmodule

// File: rtl/series_cu.sv
// Power-series evaluator controller: term counter k, multiplier wait counter m, start/busy/valid.
// Define SERIES_CU_EARLY_EXIT_EN to finish early when the term register reads zero in ADD.
//
// state | meaning
// IDLE  | waiting for start
// INIT  | load x, term=1, clear accumulator, k<-0
// ADD   | accumulate term k; last term or early exit goes to DONE
// MUL   | wait MUL_LAT cycles for the product
// LD    | load product into term register, k++
// DONE  | one-cycle valid pulse
module series_cu
  import series_cu_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int MUL_LAT = 1,
  localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_term_zero,
  output logic             o_ldX,
  output logic             o_ldTmp,
  output logic             o_selTmp,
  output logic             o_clrAcc,
  output logic             o_ldAcc,
  output logic [CNT_W-1:0] o_addr,
  output logic             o_busy,
  output logic             o_valid
);

  localparam int M_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);

  state_t             r_state;
  state_t             w_nxt;
  logic [CNT_W-1:0]   w_k;
  logic [CNT_W-1:0]   w_k_inc;
  logic [M_W-1:0]     w_m;
  logic               w_k_tc;
  logic               w_m_tc;
  logic               w_exit;
  logic [CNT_W-1:0]   w_addr_nxt;

  logic               r_ldX;
  logic               r_ldTmp;
  logic               r_selTmp;
  logic               r_clrAcc;
  logic               r_ldAcc;
  logic [CNT_W-1:0]   r_addr;
  logic               r_busy;
  logic               r_valid;

  // k is also cleared leaving DONE so IDLE and INIT present address 0.
  series_cnt #(.W(CNT_W), .MAX(N_TERMS - 1)) u_k_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   ((r_state == INIT) || (r_state == DONE)),
    .i_en    (r_state == LD),
    .o_cnt   (w_k),
    .o_tc    (w_k_tc)
  );

  series_cnt #(.W(M_W), .MAX(MUL_LAT - 1)) u_m_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (r_state == ADD),
    .i_en    ((r_state == MUL) && !w_m_tc),
    .o_cnt   (w_m),
    .o_tc    (w_m_tc)
  );

`ifdef SERIES_CU_EARLY_EXIT_EN
  assign w_exit = w_k_tc | i_term_zero;
`else
  logic w_unused_term_zero;
  assign w_unused_term_zero = i_term_zero;
  assign w_exit = w_k_tc;
`endif

  logic [M_W-1:0] w_unused_m;
  assign w_unused_m = w_m;

  assign w_k_inc = w_k + CNT_W'(1);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nxt = INIT;
      INIT:    w_nxt = ADD;
      ADD:     w_nxt = w_exit ? DONE : MUL;
      MUL:     if (w_m_tc) w_nxt = LD;
      LD:      w_nxt = ADD;
      DONE:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Address the state being entered will show, using the k value it will hold.
  always_comb begin
    w_addr_nxt = '0;
    case (w_nxt)
      MUL, LD: w_addr_nxt = w_k_inc;
      ADD:     w_addr_nxt = (r_state == LD) ? w_k_inc : '0;
      DONE:    w_addr_nxt = w_k;
      default: w_addr_nxt = '0;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_ldX    <= 1'b0;
      r_ldTmp  <= 1'b0;
      r_selTmp <= 1'b0;
      r_clrAcc <= 1'b0;
      r_ldAcc  <= 1'b0;
      r_addr   <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_ldX    <= (w_nxt == INIT);
      r_ldTmp  <= (w_nxt == INIT) || (w_nxt == LD);
      r_selTmp <= (w_nxt == INIT);
      r_clrAcc <= (w_nxt == INIT);
      r_ldAcc  <= (w_nxt == ADD);
      r_addr   <= w_addr_nxt;
      r_busy   <= (w_nxt == INIT) || (w_nxt == ADD) || (w_nxt == MUL) || (w_nxt == LD);
      r_valid  <= (w_nxt == DONE);
    end
  end

  assign o_ldX    = r_ldX;
  assign o_ldTmp  = r_ldTmp;
  assign o_selTmp = r_selTmp;
  assign o_clrAcc = r_clrAcc;
  assign o_ldAcc  = r_ldAcc;
  assign o_addr   = r_addr;
  assign o_busy   = r_busy;
  assign o_valid  = r_valid;

endmodule

// File: tb/tb_series_cu.sv
// Directed bench for series_cu: three instances (8/1, 4/3, 2/1) sharing clock and reset.
module tb_series_cu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_start, a_tz, b_start, b_tz, c_start, c_tz;

  logic a_ldX, a_ldTmp, a_selTmp, a_clrAcc, a_ldAcc, a_busy, a_valid;
  logic b_ldX, b_ldTmp, b_selTmp, b_clrAcc, b_ldAcc, b_busy, b_valid;
  logic c_ldX, c_ldTmp, c_selTmp, c_clrAcc, c_ldAcc, c_busy, c_valid;
  logic [3:0] a_addr;
  logic [2:0] b_addr;
  logic [1:0] c_addr;

  int checks = 0;
  int failures = 0;

  series_cu #(.N_TERMS(8), .MUL_LAT(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_term_zero(a_tz),
    .o_ldX(a_ldX), .o_ldTmp(a_ldTmp), .o_selTmp(a_selTmp), .o_clrAcc(a_clrAcc),
    .o_ldAcc(a_ldAcc), .o_addr(a_addr), .o_busy(a_busy), .o_valid(a_valid));

  series_cu #(.N_TERMS(4), .MUL_LAT(3)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_term_zero(b_tz),
    .o_ldX(b_ldX), .o_ldTmp(b_ldTmp), .o_selTmp(b_selTmp), .o_clrAcc(b_clrAcc),
    .o_ldAcc(b_ldAcc), .o_addr(b_addr), .o_busy(b_busy), .o_valid(b_valid));

  series_cu #(.N_TERMS(2), .MUL_LAT(1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(c_start), .i_term_zero(c_tz),
    .o_ldX(c_ldX), .o_ldTmp(c_ldTmp), .o_selTmp(c_selTmp), .o_clrAcc(c_clrAcc),
    .o_ldAcc(c_ldAcc), .o_addr(c_addr), .o_busy(c_busy), .o_valid(c_valid));

  // Control signature order: ldX ldTmp selTmp clrAcc ldAcc busy valid
  logic [6:0] a_sig, b_sig, c_sig;
  assign a_sig = {a_ldX, a_ldTmp, a_selTmp, a_clrAcc, a_ldAcc, a_busy, a_valid};
  assign b_sig = {b_ldX, b_ldTmp, b_selTmp, b_clrAcc, b_ldAcc, b_busy, b_valid};
  assign c_sig = {c_ldX, c_ldTmp, c_selTmp, c_clrAcc, c_ldAcc, c_busy, c_valid};

  localparam logic [6:0] SIG_IDLE = 7'b0000000;
  localparam logic [6:0] SIG_INIT = 7'b1111010;
  localparam logic [6:0] SIG_ADD  = 7'b0000110;
  localparam logic [6:0] SIG_MUL  = 7'b0000010;
  localparam logic [6:0] SIG_LD   = 7'b0100010;
  localparam logic [6:0] SIG_DONE = 7'b0000001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int adds, lds, muls, vcyc, bad, valids, maxaddr;
  logic [27:0] addr_seq;
  logic seen_valid;
  logic [6:0] exp_sig [7];
  int exp_addr [7];

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_tz = 0; b_start = 0; b_tz = 0; c_start = 0; c_tz = 0;
    step(); step();
    chk("rst_a", {a_sig, 4'(a_addr)}, 32'h0);
    chk("rst_b", {b_sig, 3'(b_addr)}, 32'h0);
    chk("rst_c", {c_sig, 2'(c_addr)}, 32'h0);
    rst_n = 1'b1;
    step();

    // Nominal: N=8, LAT=1
    a_start = 1; step(); a_start = 0;
    chk("a_init_sig", a_sig, SIG_INIT);
    chk("a_init_addr", a_addr, 0);
    adds = 0; lds = 0; vcyc = -1; addr_seq = '0;
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      step();
      if (a_ldAcc) adds++;
      if (a_ldTmp && !a_selTmp) lds++;
      if (c <= 7) addr_seq = {addr_seq[23:0], a_addr};
      if (a_valid) vcyc = c;
    end
    chk("a_ldacc_count", adds, 8);
    chk("a_ld_count", lds, 7);
    chk("a_valid_cycle", vcyc, 23);
    chk("a_addr_seq", addr_seq, 28'h0111222);
    step();
    chk("a_after_done", a_sig, SIG_IDLE);

    // Multi-cycle multiplier: N=4, LAT=3
    b_start = 1; step(); b_start = 0;
    lds = 0; muls = 0; vcyc = -1;
    for (int c = 1; c <= 60 && vcyc < 0; c++) begin
      step();
      if (b_ldTmp && !b_selTmp) lds++;
      if (b_sig == SIG_MUL) muls++;
      if (b_valid) vcyc = c;
    end
    chk("b_ld_count", lds, 3);
    chk("b_mul_cycles", muls, 9);
    chk("b_valid_cycle", vcyc, 17);

    // Minimum config: N=2, LAT=1
    exp_sig  = '{SIG_INIT, SIG_ADD, SIG_MUL, SIG_LD, SIG_ADD, SIG_DONE, SIG_IDLE};
    exp_addr = '{0, 0, 1, 1, 1, 1, 0};
    maxaddr = 0;
    c_start = 1; step(); c_start = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      chk($sformatf("c_sig_%0d", i), c_sig, exp_sig[i]);
      chk($sformatf("c_addr_%0d", i), c_addr, exp_addr[i]);
      if (int'(c_addr) > maxaddr) maxaddr = int'(c_addr);
    end
    chk("c_addr_max", maxaddr, 1);

    // Handshake: start held for 60 cycles, period is 7 (L=5, DONE, one IDLE)
    bad = 0; valids = 0;
    c_start = 1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (c_ldX !== ((c % 7) == 0)) bad++;
      if (c_valid !== ((c % 7) == 5)) bad++;
      if (c_valid) valids++;
    end
    c_start = 0;
    chk("c_b2b_pattern", bad, 0);
    chk("c_b2b_valids", valids, 8);
    for (int i = 0; i < 20 && (c_busy || c_valid); i++) step();
    chk("c_drain_idle", c_sig, SIG_IDLE);

    // Early exit: term_zero high on the third ADD
    a_start = 1; step(); a_start = 0;
    adds = 0; vcyc = -1;
    for (int c = 1; c <= 40 && vcyc < 0; c++) begin
      step();
      if (a_ldAcc) adds++;
      a_tz = a_ldAcc && (adds == 3);
      if (a_valid) vcyc = c;
    end
    a_tz = 0;
`ifdef SERIES_CU_EARLY_EXIT_EN
    chk("a_ee_ldacc", adds, 3);
    chk("a_ee_valid_cycle", vcyc, 8);
`else
    chk("a_ee_ldacc", adds, 8);
    chk("a_ee_valid_cycle", vcyc, 23);
`endif
    step();
    chk("a_ee_idle", a_sig, SIG_IDLE);

    // Reset mid-MUL
    a_start = 1; step(); a_start = 0;
    step(); step();
    chk("a_in_mul", a_sig, SIG_MUL);
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_rst", {a_sig, 4'(a_addr)}, 32'h0);
    seen_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (a_valid) seen_valid = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (a_valid || a_busy) seen_valid = 1;
    end
    chk("a_rst_no_valid", seen_valid, 0);
    chk("a_rst_idle", {a_sig, 4'(a_addr)}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
